// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    // Misaligned, or word index beyond the memory.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory signals of the data-memory arbiter.
interface dmem_arbiter_if;
    logic        req0, we0, done0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, done1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        mem_mrd, mem_mwrt;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        output done0, err0, rdata0, done1, err1, rdata1,
        output mem_mrd, mem_mwrt, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        input  done0, err0, rdata0, done1, err1, rdata1,
        input  mem_mrd, mem_mwrt, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter_pick.sv
// Combinational winner select between the two requesters.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic starve,
    output logic win,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        win   = P0;
        if (req1 && !req0) begin
            win = P1;
        end else if (req0 && req1) begin
            if (FIXED_PRIO != 0) win = starve ? P1 : P0;
            else                 win = ~last;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port word data memory: IDLE -> ACCESS -> RESP.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH        = 512,
    parameter int          FIXED_PRIO   = 0,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    dmem_arbiter_if.slave bus
);

    localparam int W1_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [W1_W-1:0] W1_MAX = W1_W'(STARVE_LIMIT);

    state_t          state;
    logic            win_q, bad_q, last_q;
    logic [W1_W-1:0] wait1_q;
    logic            mrd_q, mwrt_q;
    logic [31:0]     maddr_q, mwdata_q;
    logic            done0_q, err0_q, done1_q, err1_q;
    logic [31:0]     rdata0_q, rdata1_q;

    logic            win, valid, starve;
    logic            sel_we, sel_bad;
    logic [31:0]     sel_addr, sel_wdata, acc_rdata;

    assign starve    = (wait1_q >= W1_MAX);
    assign sel_we    = win ? bus.we1    : bus.we0;
    assign sel_addr  = win ? bus.addr1  : bus.addr0;
    assign sel_wdata = win ? bus.wdata1 : bus.wdata0;
    assign sel_bad   = addr_bad(sel_addr, DEPTH);
    // Read strobe already encodes "read and not bad".
    assign acc_rdata = mrd_q ? bus.mem_rdata : 32'h0;

    dmem_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last_q),
        .starve (starve),
        .win    (win),
        .valid  (valid)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            win_q    <= P0;
            bad_q    <= 1'b0;
            last_q   <= P1;
            wait1_q  <= '0;
            mrd_q    <= 1'b0;
            mwrt_q   <= 1'b0;
            maddr_q  <= 32'h0;
            mwdata_q <= 32'h0;
            done0_q  <= 1'b0;
            err0_q   <= 1'b0;
            rdata0_q <= 32'h0;
            done1_q  <= 1'b0;
            err1_q   <= 1'b0;
            rdata1_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        win_q    <= win;
                        bad_q    <= sel_bad;
                        mrd_q    <= !sel_we && !sel_bad;
                        mwrt_q   <= sel_we && !sel_bad;
                        maddr_q  <= sel_addr;
                        mwdata_q <= sel_wdata;
                        if (win == P1)
                            wait1_q <= '0;
                        else if (bus.req1 && wait1_q != W1_MAX)
                            wait1_q <= wait1_q + W1_W'(1);
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    mrd_q    <= 1'b0;
                    mwrt_q   <= 1'b0;
                    maddr_q  <= 32'h0;
                    mwdata_q <= 32'h0;
                    last_q   <= win_q;
                    done0_q  <= (win_q == P0);
                    err0_q   <= (win_q == P0) && bad_q;
                    rdata0_q <= (win_q == P0) ? acc_rdata : 32'h0;
                    done1_q  <= (win_q == P1);
                    err1_q   <= (win_q == P1) && bad_q;
                    rdata1_q <= (win_q == P1) ? acc_rdata : 32'h0;
                    state    <= RESP;
                end
                RESP: begin
                    done0_q  <= 1'b0;
                    err0_q   <= 1'b0;
                    rdata0_q <= 32'h0;
                    done1_q  <= 1'b0;
                    err1_q   <= 1'b0;
                    rdata1_q <= 32'h0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_mrd   = mrd_q;
    assign bus.mem_mwrt  = mwrt_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = mwdata_q;
    assign bus.done0     = done0_q;
    assign bus.err0      = err0_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.done1     = done1_q;
    assign bus.err1      = err1_q;
    assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance, each with its own memory.
module tb_dmem_arbiter;

    localparam int DEPTH = 512;
    localparam int LIMIT = 8;

    typedef struct packed {
        logic        req0, we0;
        logic [31:0] addr0, wdata0;
        logic        req1, we1;
        logic [31:0] addr1, wdata1;
    } ins_t;

    typedef struct packed {
        logic        done0, err0;
        logic [31:0] rdata0;
        logic        done1, err1;
        logic [31:0] rdata1;
        logic        mrd, mwrt;
        logic [31:0] maddr, mwdata;
    } outs_t;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr, wdata;
        logic [1:0]  exp_ctl;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    ins_t  in_d [2];
    outs_t act  [2];
    logic [31:0] phys_rr [DEPTH];
    logic [31:0] phys_fp [DEPTH];

    // Reference model state
    logic [31:0] refmem [2][DEPTH];
    int          busy [2], last [2], wait1 [2], g_port [2];
    logic        g_we [2], g_bad [2];
    logic [31:0] g_addr [2], g_wdata [2];

    int checks = 0, errors = 0, cyc = 0;

    dmem_arbiter_if if_rr();
    dmem_arbiter_if if_fp();

    assign if_rr.req0 = in_d[0].req0;   assign if_rr.we0 = in_d[0].we0;
    assign if_rr.addr0 = in_d[0].addr0; assign if_rr.wdata0 = in_d[0].wdata0;
    assign if_rr.req1 = in_d[0].req1;   assign if_rr.we1 = in_d[0].we1;
    assign if_rr.addr1 = in_d[0].addr1; assign if_rr.wdata1 = in_d[0].wdata1;
    assign if_fp.req0 = in_d[1].req0;   assign if_fp.we0 = in_d[1].we0;
    assign if_fp.addr0 = in_d[1].addr0; assign if_fp.wdata0 = in_d[1].wdata0;
    assign if_fp.req1 = in_d[1].req1;   assign if_fp.we1 = in_d[1].we1;
    assign if_fp.addr1 = in_d[1].addr1; assign if_fp.wdata1 = in_d[1].wdata1;

    assign act[0] = {if_rr.done0, if_rr.err0, if_rr.rdata0, if_rr.done1, if_rr.err1, if_rr.rdata1,
                     if_rr.mem_mrd, if_rr.mem_mwrt, if_rr.mem_addr, if_rr.mem_wdata};
    assign act[1] = {if_fp.done0, if_fp.err0, if_fp.rdata0, if_fp.done1, if_fp.err1, if_fp.rdata1,
                     if_fp.mem_mrd, if_fp.mem_mwrt, if_fp.mem_addr, if_fp.mem_wdata};

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    assign if_rr.mem_rdata = phys_rr[if_rr.mem_addr[10:2]];
    assign if_fp.mem_rdata = phys_fp[if_fp.mem_addr[10:2]];

    always @(posedge clk) begin
        if (mem_init) for (int i = 0; i < DEPTH; i++) phys_rr[i] <= init_word(i);
        else if (if_rr.mem_mwrt) phys_rr[if_rr.mem_addr[10:2]] <= if_rr.mem_wdata;
    end
    always @(posedge clk) begin
        if (mem_init) for (int i = 0; i < DEPTH; i++) phys_fp[i] <= init_word(i);
        else if (if_fp.mem_mwrt) phys_fp[if_fp.mem_addr[10:2]] <= if_fp.mem_wdata;
    end

    dmem_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(0), .STARVE_LIMIT(LIMIT)) dut_rr (
        .CLK(clk), .RESET(rst_n), .bus(if_rr.slave));
    dmem_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1), .STARVE_LIMIT(LIMIT)) dut_fp (
        .CLK(clk), .RESET(rst_n), .bus(if_fp.slave));

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected outputs: phase 1 drives memory, phase 2 answers the winner.
    function automatic outs_t model_out(input int d);
        outs_t       o;
        logic [31:0] rd;
        o  = '0;
        rd = 32'h0;
        if (busy[d] == 1) begin
            o.mrd    = !g_we[d] && !g_bad[d];
            o.mwrt   = g_we[d] && !g_bad[d];
            o.maddr  = g_addr[d];
            o.mwdata = g_wdata[d];
        end else if (busy[d] == 2) begin
            if (!g_we[d] && !g_bad[d]) rd = refmem[d][g_addr[d] / 4];
            if (g_port[d] == 0) begin o.done0 = 1'b1; o.err0 = g_bad[d]; o.rdata0 = rd; end
            else                begin o.done1 = 1'b1; o.err1 = g_bad[d]; o.rdata1 = rd; end
        end
        return o;
    endfunction

    task automatic model_step(input int d);
        logic r0, r1;
        int   w;
        if (!rst_n) begin
            busy[d] = 0; last[d] = 1; wait1[d] = 0;
            return;
        end
        if (busy[d] == 0) begin
            r0 = in_d[d].req0;
            r1 = in_d[d].req1;
            if (r0 || r1) begin
                if (r0 && r1) w = (d == 1) ? ((wait1[d] >= LIMIT) ? 1 : 0) : 1 - last[d];
                else          w = r1 ? 1 : 0;
                if (w == 1)  wait1[d] = 0;
                else if (r1) wait1[d]++;
                g_port[d]  = w;
                g_we[d]    = w ? in_d[d].we1 : in_d[d].we0;
                g_addr[d]  = w ? in_d[d].addr1 : in_d[d].addr0;
                g_wdata[d] = w ? in_d[d].wdata1 : in_d[d].wdata0;
                g_bad[d]   = (g_addr[d] % 4 != 0) || (g_addr[d] / 4 >= DEPTH);
                busy[d]    = 1;
            end
        end else if (busy[d] == 1) begin
            if (g_we[d] && !g_bad[d]) refmem[d][g_addr[d] / 4] = g_wdata[d];
            last[d] = g_port[d];
            busy[d] = 2;
        end else begin
            busy[d] = 0;
        end
    endtask

    task automatic tick();
        outs_t e;
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_step(d);
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            e = model_out(d);
            checks++;
            if (act[d] !== e) begin
                errors++;
                $display("FAIL model_%s cyc %0d: got %h expected %h", (d == 0) ? "rr" : "fp", cyc, act[d], e);
            end
        end
    endtask

    task automatic set_port(input int d, input int p, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            in_d[d].req0 = req; in_d[d].we0 = we; in_d[d].addr0 = addr; in_d[d].wdata0 = wdata;
        end else begin
            in_d[d].req1 = req; in_d[d].we1 = we; in_d[d].addr1 = addr; in_d[d].wdata1 = wdata;
        end
    endtask

    task automatic do_txn(input vec_t v, input string name);
        for (int d = 0; d < 2; d++) set_port(d, v.port, 1'b1, v.we, v.addr, v.wdata);
        tick();
        chk32({name, "_memctl"}, {30'h0, act[0].mrd, act[0].mwrt}, {30'h0, v.exp_ctl});
        tick();
        for (int d = 0; d < 2; d++) begin
            chk32({name, "_done"},  {31'h0, (v.port == 0) ? act[d].done0 : act[d].done1}, 32'h1);
            chk32({name, "_other"}, {31'h0, (v.port == 0) ? act[d].done1 : act[d].done0}, 32'h0);
            chk32({name, "_err"},   {31'h0, (v.port == 0) ? act[d].err0 : act[d].err1}, {31'h0, v.exp_err});
            chk32({name, "_rdata"}, (v.port == 0) ? act[d].rdata0 : act[d].rdata1, v.exp_rdata);
        end
        for (int d = 0; d < 2; d++) set_port(d, v.port, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int          r;
        r = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 63)) << 2;
        if (r == 0) a = a | 32'($urandom_range(1, 3));
        if (r == 1) a = 32'(DEPTH * 4) + (32'($urandom_range(0, 1000)) << 2);
        if (r == 2) a = 32'hFFFF_FFFC;
        return a;
    endfunction

    task automatic drive_random(input int d);
        outs_t e;
        logic  req, done;
        e = model_out(d);
        for (int p = 0; p < 2; p++) begin
            req  = (p == 0) ? in_d[d].req0 : in_d[d].req1;
            done = (p == 0) ? e.done0 : e.done1;
            if (!req || done) begin
                if ($urandom_range(0, 99) < (req ? 50 : 35))
                    set_port(d, p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                else
                    set_port(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
    endtask

    vec_t vecs [11];
    vec_t v;
    int   n, exp_p, streak, p1_wins, last_done;
    logic got;

    initial begin
        vecs[0]  = '{0, 1'b1, 32'h10,        32'hDEADBEEF, 2'b01, 1'b0, 32'h0};
        vecs[1]  = '{0, 1'b0, 32'h10,        32'h0,        2'b10, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1, 1'b0, 32'h2,         32'h0,        2'b00, 1'b1, 32'h0};
        vecs[3]  = '{1, 1'b1, 32'h800,       32'h12345678, 2'b00, 1'b1, 32'h0};
        vecs[4]  = '{1, 1'b1, 32'h7FC,       32'hA5A5A5A5, 2'b01, 1'b0, 32'h0};
        vecs[5]  = '{1, 1'b0, 32'h7FC,       32'h0,        2'b10, 1'b0, 32'hA5A5A5A5};
        vecs[6]  = '{0, 1'b1, 32'h20,        32'h11111111, 2'b01, 1'b0, 32'h0};
        vecs[7]  = '{0, 1'b0, 32'hFFFFFFFC,  32'h0,        2'b00, 1'b1, 32'h0};
        vecs[8]  = '{1, 1'b0, 32'h20,        32'h0,        2'b10, 1'b0, 32'h11111111};
        vecs[9]  = '{0, 1'b0, 32'h801,       32'h0,        2'b00, 1'b1, 32'h0};
        vecs[10] = '{0, 1'b0, 32'h0,         32'h0,        2'b10, 1'b0, 32'hC0DE0000};

        in_d[0] = '0;
        in_d[1] = '0;
        for (int d = 0; d < 2; d++) begin
            busy[d] = 0; last[d] = 1; wait1[d] = 0;
            for (int i = 0; i < DEPTH; i++) refmem[d][i] = init_word(i);
        end

        // Reset: outputs clear asynchronously
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (act[d] !== outs_t'(0)) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %h expected 0", d, act[d]);
            end
        end
        tick();
        tick();
        mem_init = 1'b0;
        rst_n    = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset during a write access: strobe drops at once, write is lost
        for (int d = 0; d < 2; d++) set_port(d, 0, 1'b1, 1'b1, 32'h20, 32'h5A);
        tick();
        chk32("rst_mid_pre_mwrt", {31'h0, act[0].mwrt}, 32'h1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (act[d] !== outs_t'(0)) begin
                errors++;
                $display("FAIL rst_mid_async dut%0d: got %h expected 0", d, act[d]);
            end
        end
        for (int d = 0; d < 2; d++) set_port(d, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        v = '{0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h11111111};
        do_txn(v, "rst_mid_readback");

        // REQ1 raised during P0's RESP is picked in the following IDLE
        for (int d = 0; d < 2; d++) set_port(d, 0, 1'b1, 1'b1, 32'h30, 32'h0BADF00D);
        tick();
        tick();
        chk32("resp_p0_done", {31'h0, act[0].done0}, 32'h1);
        for (int d = 0; d < 2; d++) begin
            set_port(d, 0, 1'b0, 1'b0, 32'h0, 32'h0);
            set_port(d, 1, 1'b1, 1'b0, 32'h30, 32'h0);
        end
        n = 0;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            tick();
            n++;
            if (act[0].done1) got = 1'b1;
        end
        chk32("resp_req_latency", 32'(n), 32'd3);
        chk32("resp_req_rdata", act[0].rdata1, 32'h0BADF00D);
        for (int d = 0; d < 2; d++) set_port(d, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Continuous tie: RR alternates from P0; FP grants P1 after 8 P0 wins
        for (int d = 0; d < 2; d++) begin
            set_port(d, 0, 1'b1, 1'b0, 32'h0, 32'h0);
            set_port(d, 1, 1'b1, 1'b0, 32'h4, 32'h0);
        end
        exp_p = 0; streak = 0; p1_wins = 0; last_done = -1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (act[0].done0 || act[0].done1) begin
                chk32("rr_grant", {31'h0, act[0].done1}, 32'(exp_p));
                chk32("rr_one_done", {31'h0, act[0].done0 & act[0].done1}, 32'h0);
                if (last_done >= 0) chk32("rr_spacing", 32'(cyc - last_done), 32'd3);
                last_done = cyc;
                exp_p = 1 - exp_p;
            end
            if (act[1].done0) streak++;
            if (act[1].done1) begin
                chk32("fp_starve_streak", 32'(streak), 32'(LIMIT));
                streak = 0;
                p1_wins++;
            end
        end
        chk32("fp_p1_wins", 32'(p1_wins), 32'd2);

        // Randomised traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            for (int d = 0; d < 2; d++) drive_random(d);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
